pipe_ctrl: RTL and testbench

- Pipeline hazard/flush controller for the 5-stage TiniSOC core; drives the flush and hazard inputs of the pipeline register walls.
- Detects load-use hazards and taken branches.
- Sequences a post-reset pipeline scrub and a debug drain/halt handshake.
- Outputs are decoded from a posedge state register plus current-cycle inputs, so they are stable before the walls' negedge capture.

---
 rtl/pipe_ctrl_if.sv | 35 +++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard/flush control bundle between the pipeline walls and pipe_ctrl.
// master drives stage status, slave (pipe_ctrl) returns wall controls.
interface pipe_ctrl_if;
   logic [4:0] iID_ra_addr;
   logic [4:0] iID_rb_addr;
   logic       iID_use_ra;
   logic       iID_use_rb;
   logic       iEX_do_dm_read;
   logic [4:0] iEX_write_reg_addr;
   logic       iEX_branch_taken;
   logic       iDRAIN_req;
   logic       do_flush_REG1;
   logic       do_flush_REG2;
   logic       do_flush_REG3;
   logic       do_flush_REG4;
   logic       do_hazard;
   logic       oPC_hold;
   logic       oDRAIN_ack;

   modport master (
      output iID_ra_addr, iID_rb_addr, iID_use_ra, iID_use_rb,
      output iEX_do_dm_read, iEX_write_reg_addr, iEX_branch_taken,
      output iDRAIN_req,
      input  do_flush_REG1, do_flush_REG2, do_flush_REG3,
      input  do_flush_REG4, do_hazard, oPC_hold, oDRAIN_ack
   );

   modport slave (
      input  iID_ra_addr, iID_rb_addr, iID_use_ra, iID_use_rb,
      input  iEX_do_dm_read, iEX_write_reg_addr, iEX_branch_taken,
      input  iDRAIN_req,
      output do_flush_REG1, do_flush_REG2, do_flush_REG3,
      output do_flush_REG4, do_hazard, oPC_hold, oDRAIN_ack
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller: reset scrub, load-use, branch, drain/halt.
// Optional PIPE_CTRL_STATS_EN adds saturating stall/flush counters.
module pipe_ctrl #(
   parameter int RST_FLUSH_CYCLES = 4,
   parameter int DRAIN_CYCLES     = 4
) (
   input  logic        clock,
   input  logic        reset,
`ifdef PIPE_CTRL_STATS_EN
   output logic [15:0] oSTAT_stall_cnt,
   output logic [15:0] oSTAT_flush_cnt,
`endif
   pipe_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {INIT, RUN, DRAIN, HALTED} state_t;

   localparam logic [3:0] RF_LAST = 4'(RST_FLUSH_CYCLES - 1);
   localparam logic [3:0] DR_LAST = 4'(DRAIN_CYCLES - 1);

   state_t     state, nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       load_use;
   logic       br;

   assign br = bus.iEX_branch_taken;

   assign load_use = bus.iEX_do_dm_read &
      ((bus.iID_use_ra & (bus.iID_ra_addr == bus.iEX_write_reg_addr)) |
       (bus.iID_use_rb & (bus.iID_rb_addr == bus.iEX_write_reg_addr)));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      nxt               = state;
      cnt_nxt           = cnt;
      bus.do_flush_REG1 = 1'b0;
      bus.do_flush_REG2 = 1'b0;
      bus.do_flush_REG3 = 1'b0;
      bus.do_flush_REG4 = 1'b0;
      bus.do_hazard     = 1'b0;
      bus.oPC_hold      = 1'b0;
      bus.oDRAIN_ack    = 1'b0;
      unique case (state)
         INIT: begin
            bus.do_flush_REG1 = 1'b1;
            bus.do_flush_REG2 = 1'b1;
            bus.do_flush_REG3 = 1'b1;
            bus.do_flush_REG4 = 1'b1;
            bus.oPC_hold      = 1'b1;
            cnt_nxt           = cnt + 4'd1;
            if (cnt == RF_LAST) begin
               nxt     = RUN;
               cnt_nxt = '0;
            end
         end
         RUN: begin
            // A taken branch squashes the dependent instruction anyway.
            if (br) begin
               bus.do_flush_REG1 = 1'b1;
               bus.do_flush_REG2 = 1'b1;
            end else if (load_use) begin
               bus.do_hazard = 1'b1;
               bus.oPC_hold  = 1'b1;
            end
            if (bus.iDRAIN_req) begin
               nxt     = DRAIN;
               cnt_nxt = '0;
            end
         end
         DRAIN: begin
            bus.do_flush_REG1 = 1'b1;
            bus.do_flush_REG2 = br;
            bus.do_hazard     = load_use;
            bus.oPC_hold      = 1'b1;
            cnt_nxt           = cnt + 4'd1;
            if (cnt == DR_LAST) begin
               nxt     = HALTED;
               cnt_nxt = '0;
            end
         end
         HALTED: begin
            bus.do_flush_REG1 = 1'b1;
            bus.do_flush_REG2 = 1'b1;
            bus.oPC_hold      = 1'b1;
            bus.oDRAIN_ack    = 1'b1;
            if (!bus.iDRAIN_req) begin
               nxt     = RUN;
               cnt_nxt = '0;
            end
         end
         default: begin
            nxt     = INIT;
            cnt_nxt = '0;
         end
      endcase
   end

`ifdef PIPE_CTRL_STATS_EN
   logic br_flush;

   assign br_flush = br & ((state == RUN) | (state == DRAIN));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         oSTAT_stall_cnt <= '0;
         oSTAT_flush_cnt <= '0;
      end else begin
         if (bus.do_hazard && oSTAT_stall_cnt != 16'hFFFF)
            oSTAT_stall_cnt <= oSTAT_stall_cnt + 16'd1;
         if (br_flush && oSTAT_flush_cnt != 16'hFFFF)
            oSTAT_flush_cnt <= oSTAT_flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed plan cases then random traffic.
// Expected outputs come from a cycle-level reference model of the rules.
module tb_pipe_ctrl;

   localparam int RF = 4;
   localparam int DC = 4;

   logic clock;
   logic reset;

   pipe_ctrl_if bus ();

`ifdef PIPE_CTRL_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   pipe_ctrl #(
      .RST_FLUSH_CYCLES(RF),
      .DRAIN_CYCLES    (DC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
`ifdef PIPE_CTRL_STATS_EN
      .oSTAT_stall_cnt(stall_cnt),
      .oSTAT_flush_cnt(flush_cnt),
`endif
      .bus            (bus.slave)
   );

   initial clock = 1'b1;
   always #5 clock = ~clock;

   typedef struct {
      logic [6:0] outs;
      int         stall;
      int         flush;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: phase 0 scrub, 1 run, 2 drain, 3 halted
   int m_phase = 0;
   int m_seen  = 0;
   int m_stall = 0;
   int m_flush = 0;

   // Random-stream state
   logic drn_r = 1'b0;

   function automatic logic lu_of(
      input logic [4:0] ra, input logic [4:0] rb,
      input logic ua, input logic ub,
      input logic ld, input logic [4:0] wr);
      return ld && ((ua && ra == wr) || (ub && rb == wr));
   endfunction

   // Packed as {f1,f2,f3,f4,hazard,hold,ack}
   function automatic logic [6:0] expect_outs(input logic br, input logic lu);
      logic [6:0] o;
      o = 7'b0;
      if (m_phase == 0)
         o = 7'b1111010;
      else if (m_phase == 1)
         o = br ? 7'b1100000 : (lu ? 7'b0000110 : 7'b0);
      else if (m_phase == 2)
         o = {1'b1, br, 2'b00, lu, 1'b1, 1'b0};
      else
         o = 7'b1100011;
      return o;
   endfunction

   task automatic cycle(
      input logic rst,
      input logic [4:0] ra, input logic [4:0] rb,
      input logic ua, input logic ub,
      input logic ld, input logic [4:0] wr,
      input logic br, input logic drn);
      exp_t       e;
      logic       lu;
      logic [6:0] o;
      reset                  = rst;
      bus.iID_ra_addr        = ra;
      bus.iID_rb_addr        = rb;
      bus.iID_use_ra         = ua;
      bus.iID_use_rb         = ub;
      bus.iEX_do_dm_read     = ld;
      bus.iEX_write_reg_addr = wr;
      bus.iEX_branch_taken   = br;
      bus.iDRAIN_req         = drn;
      if (rst) begin
         m_phase = 0;
         m_seen  = 0;
         m_stall = 0;
         m_flush = 0;
      end
      lu = lu_of(ra, rb, ua, ub, ld, wr);
      o  = expect_outs(br, lu);
      e.outs  = o;
      e.stall = m_stall;
      e.flush = m_flush;
      e.cyc   = cyc;
      q.push_back(e);
      @(posedge clock);
      cyc++;
      if (!rst) begin
         if (o[2] && m_stall < 65535) m_stall++;
         if (br && (m_phase == 1 || m_phase == 2) && m_flush < 65535)
            m_flush++;
         if (m_phase == 0) begin
            m_seen++;
            if (m_seen == RF) m_phase = 1;
         end else if (m_phase == 1) begin
            if (drn) begin
               m_phase = 2;
               m_seen  = 0;
            end
         end else if (m_phase == 2) begin
            m_seen++;
            if (m_seen == DC) m_phase = 3;
         end else if (!drn) begin
            m_phase = 1;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   always @(negedge clock) begin
      exp_t       e;
      logic [6:0] act;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {bus.do_flush_REG1, bus.do_flush_REG2, bus.do_flush_REG3,
                bus.do_flush_REG4, bus.do_hazard, bus.oPC_hold,
                bus.oDRAIN_ack};
         checks++;
         if (act !== e.outs) begin
            errors++;
            $display("FAIL outs cyc=%0d got=%b want=%b", e.cyc, act, e.outs);
         end
`ifdef PIPE_CTRL_STATS_EN
         checks++;
         if (stall_cnt !== 16'(e.stall) || flush_cnt !== 16'(e.flush)) begin
            errors++;
            $display("FAIL stats cyc=%0d got=%0d/%0d want=%0d/%0d",
                     e.cyc, stall_cnt, flush_cnt, e.stall, e.flush);
         end
`endif
      end
   end

   initial begin
      reset = 1'b1;
      // Reset pulse, then scrub of RF cycles, then quiet run
      cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      idle(7);
      // Load-use on ra, then same with ra unused
      cycle(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      cycle(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      // Load-use via rb on r0, then load-use together with a branch
      cycle(1'b0, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
      cycle(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      // Drain held, hazard and branch inside drain, then release
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      cycle(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1);
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      idle(3);
      // Reset two cycles into drain
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      idle(6);
      // Stats pattern: 3 load-use cycles and 2 taken branches
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++)
         cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      idle(2);
      // Random traffic with occasional drains and resets
      for (int i = 0; i < 3000; i++) begin
         logic rst;
         if ($urandom_range(0, 15) == 0) drn_r = ~drn_r;
         rst = ($urandom_range(0, 199) == 0);
         cycle(rst,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), drn_r);
      end
      @(negedge clock);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue left=%0d want=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
